// File: rtl/gcm_ae_hw_deadlock_reporter.sv
// Deadlock reporter for the GCM_AE_HW_1x22 monitor chain: filters transient blocks,
// snapshots the block/idle vectors on confirmation and emits one report word per episode.
module gcm_ae_hw_deadlock_reporter #(
    parameter int unsigned PERSIST    = 16,
    parameter int unsigned AXIS_W     = 7,
    parameter int unsigned INST_W     = 7,
    // Reset value of deadlock_count; 0 in production, nonzero only to reach saturation quickly.
    parameter logic [15:0] COUNT_INIT = 16'h0000
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              block_in,
    input  logic [AXIS_W-1:0] axis_block_sigs,
    input  logic [INST_W-1:0] inst_idle_sigs,
    input  logic              clear,
    output logic [31:0]       report_tdata,
    output logic              report_tvalid,
    input  logic              report_tready,
    output logic              deadlock_irq,
    output logic [15:0]       deadlock_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONFIRM,
        S_REPORT,
        S_HOLD
    } state_e;

    localparam logic [15:0] PERSIST_M1 = 16'(PERSIST - 1);

    state_e              state_q, state_d;
    logic [15:0]         pcnt_q, pcnt_d;
    logic [AXIS_W-1:0]   axis_snap_q, axis_snap_d;
    logic [INST_W-1:0]   inst_snap_q, inst_snap_d;
    logic [15:0]         count_q, count_d;
    logic                irq_q, irq_d;
    logic                tvalid_q, tvalid_d;
    logic [31:0]         tdata_q, tdata_d;

    logic                confirm;
    logic [15:0]         count_inc;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        confirm = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                pcnt_d = '0;
                if (block_in) begin
                    if (PERSIST == 1) begin
                        confirm = 1'b1;
                    end else begin
                        pcnt_d  = 16'd1;
                        state_d = S_CONFIRM;
                    end
                end
            end
            S_CONFIRM: begin
                if (!block_in) begin
                    state_d = S_IDLE;
                    pcnt_d  = '0;
                end else if (pcnt_q == PERSIST_M1) begin
                    confirm = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + 16'd1;
                end
            end
            S_REPORT: begin
                if (tvalid_q && report_tready) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // One report per episode: wait for block to drop before re-arming.
                if (!block_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (confirm) begin
            state_d = S_REPORT;
            pcnt_d  = '0;
        end
    end

    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    always_comb begin
        axis_snap_d = confirm ? axis_block_sigs : axis_snap_q;
        inst_snap_d = confirm ? inst_idle_sigs  : inst_snap_q;
        count_d     = confirm ? count_inc       : count_q;
        // Set wins over a simultaneous clear.
        irq_d       = confirm | (irq_q & ~clear);

        tvalid_d = tvalid_q;
        if (confirm) begin
            tvalid_d = 1'b1;
        end else if (tvalid_q && report_tready) begin
            tvalid_d = 1'b0;
        end

        // Word is built from the incoming vectors so it carries the post-increment count.
        tdata_d = confirm ? {count_inc, 1'b0, inst_idle_sigs, 1'b0, axis_block_sigs} : tdata_q;
    end

    // NOTE: sequential state uses non-blocking assignments; the reset is asynchronous and clears everything.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= S_IDLE;
            pcnt_q      <= '0;
            axis_snap_q <= '0;
            inst_snap_q <= '0;
            count_q     <= COUNT_INIT;
            irq_q       <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            axis_snap_q <= axis_snap_d;
            inst_snap_q <= inst_snap_d;
            count_q     <= count_d;
            irq_q       <= irq_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
        end
    end

    assign report_tdata   = tdata_q;
    assign report_tvalid  = tvalid_q;
    assign deadlock_irq   = irq_q;
    assign deadlock_count = count_q;

endmodule

// File: tb/tb_gcm_ae_hw_deadlock_reporter.sv
// Bench for gcm_ae_hw_deadlock_reporter: a PERSIST=16 unit and a PERSIST=1 unit preset near
// saturation, both checked every cycle against an episode-level reference model.
module tb_gcm_ae_hw_deadlock_reporter;

    localparam int unsigned P0       = 16;
    localparam int unsigned P1       = 1;
    localparam logic [15:0] SAT_INIT = 16'hFFFD;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n;
    logic       blk  [2];
    logic [6:0] axis [2];
    logic [6:0] inst [2];
    logic       clr  [2];
    logic       rdy  [2];

    logic [31:0] tdata_0, tdata_1;
    logic        tvalid_0, tvalid_1;
    logic        irq_0, irq_1;
    logic [15:0] cnt_0, cnt_1;

    always #5 ap_clk = ~ap_clk;

    gcm_ae_hw_deadlock_reporter #(.PERSIST(P0)) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .block_in        (blk[0]),
        .axis_block_sigs (axis[0]),
        .inst_idle_sigs  (inst[0]),
        .clear           (clr[0]),
        .report_tdata    (tdata_0),
        .report_tvalid   (tvalid_0),
        .report_tready   (rdy[0]),
        .deadlock_irq    (irq_0),
        .deadlock_count  (cnt_0)
    );

    gcm_ae_hw_deadlock_reporter #(.PERSIST(P1), .COUNT_INIT(SAT_INIT)) dut_sat (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .block_in        (blk[1]),
        .axis_block_sigs (axis[1]),
        .inst_idle_sigs  (inst[1]),
        .clear           (clr[1]),
        .report_tdata    (tdata_1),
        .report_tvalid   (tvalid_1),
        .report_tready   (rdy[1]),
        .deadlock_irq    (irq_1),
        .deadlock_count  (cnt_1)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: length of the current high run, whether a new episode may start,
    // whether a report is outstanding, and the word that report must carry.
    int unsigned m_run   [2];
    bit          m_armed [2];
    bit          m_pend  [2];
    bit          m_irq   [2];
    int unsigned m_count [2];
    logic [31:0] m_word  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k]   = 0;
            m_armed[k] = 1'b1;
            m_pend[k]  = 1'b0;
            m_irq[k]   = 1'b0;
            m_word[k]  = '0;
        end
        m_count[0] = 0;
        m_count[1] = 32'(SAT_INIT);
    endtask

    task automatic model_edge(input int k);
        int unsigned p;
        bit confirm;
        p = (k == 0) ? P0 : P1;
        confirm = 1'b0;
        if (m_pend[k]) begin
            if (rdy[k]) begin
                m_pend[k]  = 1'b0;
                m_armed[k] = 1'b0;
            end
        end else if (!m_armed[k]) begin
            if (!blk[k]) m_armed[k] = 1'b1;
        end else if (blk[k]) begin
            m_run[k]++;
            if (m_run[k] == p) begin
                confirm  = 1'b1;
                m_run[k] = 0;
            end
        end else begin
            m_run[k] = 0;
        end
        if (confirm) begin
            if (m_count[k] < 32'hFFFF) m_count[k]++;
            m_word[k] = {16'(m_count[k]), 1'b0, inst[k], 1'b0, axis[k]};
            m_pend[k] = 1'b1;
            m_irq[k]  = 1'b1;
        end else if (clr[k]) begin
            m_irq[k] = 1'b0;
        end
    endtask

    task automatic check_outputs(input int k);
        logic        v, i;
        logic [15:0] c;
        logic [31:0] d;
        v = (k == 0) ? tvalid_0 : tvalid_1;
        i = (k == 0) ? irq_0    : irq_1;
        c = (k == 0) ? cnt_0    : cnt_1;
        d = (k == 0) ? tdata_0  : tdata_1;
        check($sformatf("u%0d.tvalid", k), 32'(v), 32'(m_pend[k]));
        check($sformatf("u%0d.irq", k), 32'(i), 32'(m_irq[k]));
        check($sformatf("u%0d.count", k), 32'(c), m_count[k]);
        if (m_pend[k]) check($sformatf("u%0d.tdata", k), d, m_word[k]);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            model_edge(0);
            model_edge(1);
            #1;
            check_outputs(0);
            check_outputs(1);
        end
    endtask

    initial begin
        int reports;
        ap_rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            blk[k] = 1'b0; axis[k] = '0; inst[k] = '0; clr[k] = 1'b0; rdy[k] = 1'b1;
        end
        #3;
        check("rst.tvalid", 32'(tvalid_0), 32'd0);
        check("rst.tdata", tdata_0, 32'd0);
        check("rst.irq", 32'(irq_0), 32'd0);
        check("rst.count", 32'(cnt_0), 32'd0);
        #4 ap_rst_n = 1'b1;
        model_reset();
        tick(2);

        // Transient: 15 highs then low must not confirm.
        blk[0] = 1'b1;
        tick(15);
        blk[0] = 1'b0;
        tick(3);
        check("transient.count", 32'(cnt_0), 32'd0);
        check("transient.irq", 32'(irq_0), 32'd0);

        // Confirmed deadlock with ready held high; one report for a long episode.
        axis[0] = 7'h41; inst[0] = 7'h3E; rdy[0] = 1'b1; blk[0] = 1'b1;
        tick(16);
        check("confirm.tvalid", 32'(tvalid_0), 32'd1);
        check("confirm.tdata", tdata_0, 32'h0001_3E41);
        check("confirm.irq", 32'(irq_0), 32'd1);
        tick(20);
        check("hold.tvalid", 32'(tvalid_0), 32'd0);
        blk[0] = 1'b0;
        tick(2);

        // Backpressure with toggling inputs and a clear mid-report.
        rdy[0] = 1'b0; axis[0] = 7'h15; inst[0] = 7'h2A; blk[0] = 1'b1;
        tick(16);
        check("bp.tdata0", tdata_0, 32'h0002_2A15);
        for (int c = 0; c < 10; c++) begin
            axis[0] = 7'($urandom); inst[0] = 7'($urandom); blk[0] = 1'($urandom);
            clr[0] = (c == 4);
            tick(1);
            clr[0] = 1'b0;
            check("bp.tvalid", 32'(tvalid_0), 32'd1);
            check("bp.tdata", tdata_0, 32'h0002_2A15);
        end
        check("bp.irq_cleared", 32'(irq_0), 32'd0);
        rdy[0] = 1'b1;
        tick(1);
        check("bp.accepted", 32'(tvalid_0), 32'd0);
        blk[0] = 1'b0;
        tick(2);

        // Clear on the confirm edge: set wins.
        blk[0] = 1'b1;
        tick(15);
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        check("clr_on_confirm.irq", 32'(irq_0), 32'd1);
        check("clr_on_confirm.count", 32'(cnt_0), 32'd3);
        blk[0] = 1'b0;
        tick(3);

        // PERSIST=1 re-arm and saturation: four episodes starting from FFFD.
        reports = 0;
        rdy[1] = 1'b1;
        for (int s = 0; s < 7; s++) begin
            blk[1] = (s % 2 == 0);
            axis[1] = 7'(s); inst[1] = 7'(s + 16);
            for (int r = 0; r < 2; r++) begin
                tick(1);
                if (tvalid_1) reports++;
            end
        end
        check("sat.reports", 32'(reports), 32'd4);
        check("sat.count", 32'(cnt_1), 32'h0000_FFFF);
        blk[1] = 1'b0;
        tick(2);

        // Randomised traffic on both units.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(23) == 0) blk[0] = ~blk[0];
            if ($urandom_range(2) == 0)  blk[1] = ~blk[1];
            for (int k = 0; k < 2; k++) begin
                axis[k] = 7'($urandom);
                inst[k] = 7'($urandom);
                rdy[k]  = ($urandom_range(1) == 1);
                clr[k]  = ($urandom_range(15) == 0);
            end
            tick(1);
        end

        // Reset in the middle of a pending report.
        for (int k = 0; k < 2; k++) begin
            blk[k] = 1'b0; rdy[k] = 1'b1; clr[k] = 1'b0;
        end
        tick(3);
        rdy[0] = 1'b0; blk[0] = 1'b1;
        tick(16);
        check("pre_rst.tvalid", 32'(tvalid_0), 32'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("midrst.tvalid", 32'(tvalid_0), 32'd0);
        check("midrst.tdata", tdata_0, 32'd0);
        check("midrst.irq", 32'(irq_0), 32'd0);
        check("midrst.count", 32'(cnt_0), 32'd0);
        blk[0] = 1'b0;
        #3 ap_rst_n = 1'b1;
        model_reset();
        tick(5);
        check("post_rst.tvalid", 32'(tvalid_0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
